alu_issue_scheduler: RTL and testbench
======================================

ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 Parameter RS_SIZE, default 8, number of reservation-station entries competing for the single ALU (power of two, 2..16).
REQ-002 Parameter IDX_W, default 3, width of the entry index; SHALL equal log2(RS_SIZE).
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-low.
REQ-005 rdy_in  input  1  when low, all state and outputs SHALL hold.
REQ-006 clear  input  1  pipeline flush (branch mispredict), synchronous.
REQ-007 cdb_stall  input  1  result bus cannot accept an ALU result next cycle.
REQ-008 req_valid  input  RS_SIZE  bit i = entry i has both operands and is ALU-bound.
REQ-009 req_rob  input  RS_SIZE*`ROB_BIT  packed ROB tags; entry i at bits [i*`ROB_BIT +: `ROB_BIT].
REQ-010 rob_head  input  `ROB_BIT  tag of the oldest ROB entry; used only with REQ-027.
REQ-011 grant  output  RS_SIZE  registered one-hot issue grant; zero when idle.
REQ-012 alu_valid  output  1  registered; drives the ALU valid input.
REQ-013 alu_rs_idx  output  IDX_W  index of the granted entry; the RS muxes vi/vj/op/op_type/op_addition with it.
REQ-014 alu_rob_entry  output  `ROB_BIT  tag of the granted entry; drives the ALU rob_entry input.

Function
REQ-015 Eligible set each cycle = req_valid AND NOT last_grant, where last_grant is the grant register value, so an entry granted at edge t is never re-granted at edge t+1.
REQ-016 Round-robin pointer ptr (IDX_W bits) selects the first eligible index scanning ptr, ptr+1, ..., wrapping modulo RS_SIZE.
REQ-017 On an edge with rdy_in=1, clear=0, cdb_stall=0 and a non-empty eligible set: grant<=onehot(sel), alu_valid<=1, alu_rs_idx<=sel, alu_rob_entry<=req_rob[sel], ptr<=(sel+1) mod RS_SIZE.
REQ-018 On an edge with rdy_in=1 and an empty eligible set, or cdb_stall=1: grant<=0, alu_valid<=0; ptr, alu_rs_idx and alu_rob_entry hold.
REQ-019 Issue latency: request visible at edge t -> grant/alu_valid high after edge t; ALU result ready after edge t+1.
REQ-020 At most one grant bit SHALL be set in any cycle; alu_valid SHALL equal |grant.
REQ-021 clear=1 with rdy_in=1 (priority over every other input): grant<=0, alu_valid<=0, ptr<=0.
REQ-022 rdy_in=0: every register holds, including a grant already high; clear and cdb_stall are ignored.
REQ-023 Sel wrap: ptr=RS_SIZE-1 with only entry 0 eligible -> sel=0, ptr<=1.
REQ-024 No starvation: a continuously eligible entry SHALL be granted within RS_SIZE issuing cycles (round-robin mode).

Reset
REQ-025 While rst_in=0, immediately and regardless of clock: grant=0, alu_valid=0, alu_rs_idx=0, alu_rob_entry=0, ptr=0, last_grant=0.
REQ-026 Reset deasserting mid-stream SHALL produce no grant on the first edge unless eligible requests are present at that edge.

Configuration
REQ-027 Macro ALU_SCHED_OLDEST_EN defined: selection is oldest-first; age_i=(req_rob_i - rob_head) mod 2^`ROB_BIT, smallest age wins, ties to lowest index; ptr unused and held at 0; rob_head port present.
REQ-028 Macro ALU_SCHED_OLDEST_EN undefined: round-robin per REQ-016; rob_head port present but ignored.

Verification
REQ-029 Reset: pull rst_in low between clocks -> grant=0, alu_valid=0 at once, before next edge.
REQ-030 Round-robin: req_valid=8'hFF held 8 cycles, RR mode -> grant 01,02,04,...,80 then 01; alu_rob_entry tracks req_rob each cycle.
REQ-031 Masking/wrap: ptr=7, req_valid=8'h81 held -> grant 80 then 01 then 80; never same bit on consecutive cycles.
REQ-032 Stall/pause: cdb_stall=1 one cycle -> grant 0 that cycle, ptr unchanged; rdy_in=0 three cycles with grant=04 -> grant stays 04.
REQ-033 Flush: clear=1 with req_valid=8'h10 -> grant=0, ptr=0 next edge; next grant 10.
REQ-034 Oldest-first (ALU_SCHED_OLDEST_EN): rob_head=6, entry2 tag 7, entry5 tag 1, entry6 tag 7 -> grant 04 (age 1, lowest index).

Source files
------------

// File: rtl/alu_issue_scheduler_if.sv
// Request/grant bundle between the reservation station and the ALU issue scheduler.
`ifndef ROB_BIT
`define ROB_BIT 5
`endif

interface alu_issue_scheduler_if #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = 3
);
    logic [RS_SIZE-1:0]          req_valid;
    logic [RS_SIZE*`ROB_BIT-1:0] req_rob;
    logic [`ROB_BIT-1:0]         rob_head;
    logic [RS_SIZE-1:0]          grant;
    logic                        alu_valid;
    logic [IDX_W-1:0]            alu_rs_idx;
    logic [`ROB_BIT-1:0]         alu_rob_entry;

    // Reservation station side: presents requests, consumes the grant.
    modport master (
        output req_valid, req_rob, rob_head,
        input  grant, alu_valid, alu_rs_idx, alu_rob_entry
    );

    modport slave (
        input  req_valid, req_rob, rob_head,
        output grant, alu_valid, alu_rs_idx, alu_rob_entry
    );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Single-ALU issue scheduler: grants one ready reservation-station entry per cycle.
// Define ALU_SCHED_OLDEST_EN for oldest-first selection; the default build is round-robin.
`ifndef ROB_BIT
`define ROB_BIT 5
`endif

module alu_issue_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 cdb_stall,
    alu_issue_scheduler_if.slave bus
);

    logic [RS_SIZE-1:0]  r_grant;
    logic                r_alu_valid;
    logic [IDX_W-1:0]    r_alu_rs_idx;
    logic [`ROB_BIT-1:0] r_alu_rob_entry;
    logic [IDX_W-1:0]    r_ptr;

    logic [RS_SIZE-1:0]  w_elig;
    logic [IDX_W-1:0]    w_sel;
    logic                w_any;
    logic [`ROB_BIT-1:0] w_sel_rob;

    // The entry granted last cycle sits out one cycle so its operands can be freed.
    assign w_elig = bus.req_valid & ~r_grant;

`ifdef ALU_SCHED_OLDEST_EN
    logic [`ROB_BIT-1:0] w_age;
    logic [`ROB_BIT-1:0] w_best_age;

    // Age is distance from the ROB head; strict compare keeps the lowest index on ties.
    always_comb begin
        w_sel      = '0;
        w_any      = 1'b0;
        w_age      = '0;
        w_best_age = '1;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_age = bus.req_rob[i*`ROB_BIT +: `ROB_BIT] - bus.rob_head;
            if (w_elig[i] && (!w_any || (w_age < w_best_age))) begin
                w_best_age = w_age;
                w_sel      = IDX_W'(i);
                w_any      = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] w_scan;
    logic             w_unused_head;

    assign w_unused_head = ^bus.rob_head;

    // Scanning offsets high to low leaves the first eligible entry after ptr in w_sel.
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_scan = '0;
        for (int k = RS_SIZE - 1; k >= 0; k--) begin
            w_scan = r_ptr + IDX_W'(k);
            if (w_elig[w_scan]) begin
                w_sel = w_scan;
                w_any = 1'b1;
            end
        end
    end
`endif

    assign w_sel_rob = bus.req_rob[int'(w_sel)*`ROB_BIT +: `ROB_BIT];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_grant         <= '0;
            r_alu_valid     <= 1'b0;
            r_alu_rs_idx    <= '0;
            r_alu_rob_entry <= '0;
            r_ptr           <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                r_grant     <= '0;
                r_alu_valid <= 1'b0;
                r_ptr       <= '0;
            end else if (cdb_stall || !w_any) begin
                r_grant     <= '0;
                r_alu_valid <= 1'b0;
            end else begin
                r_grant         <= RS_SIZE'(1) << w_sel;
                r_alu_valid     <= 1'b1;
                r_alu_rs_idx    <= w_sel;
                r_alu_rob_entry <= w_sel_rob;
`ifdef ALU_SCHED_OLDEST_EN
                r_ptr           <= '0;
`else
                r_ptr           <= w_sel + IDX_W'(1);
`endif
            end
        end
    end

    assign bus.grant         = r_grant;
    assign bus.alu_valid     = r_alu_valid;
    assign bus.alu_rs_idx    = r_alu_rs_idx;
    assign bus.alu_rob_entry = r_alu_rob_entry;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed self-checking bench for alu_issue_scheduler (RS_SIZE=8, entry i carries ROB tag i+10).
`ifndef ROB_BIT
`define ROB_BIT 5
`endif

module tb_alu_issue_scheduler;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear;
    logic cdb_stall;

    int checkCount = 0;
    int passCount  = 0;

    alu_issue_scheduler_if #(.RS_SIZE(8), .IDX_W(3)) bus ();

    alu_issue_scheduler #(.RS_SIZE(8), .IDX_W(3)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .clear     (clear),
        .cdb_stall (cdb_stall),
        .bus       (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic checkGrant(input string tag, input logic [7:0] expGrant,
                              input logic [2:0] expIdx, input logic [4:0] expRob);
        checkOutput({tag, ".grant"}, 32'(bus.grant), 32'(expGrant));
        checkOutput({tag, ".valid"}, 32'(bus.alu_valid), 32'(expGrant != 8'h00));
        checkOutput({tag, ".idx"}, 32'(bus.alu_rs_idx), 32'(expIdx));
        checkOutput({tag, ".rob"}, 32'(bus.alu_rob_entry), 32'(expRob));
    endtask

    task automatic applyStimulus(input logic [7:0] reqValid, input logic rdy,
                                 input logic clr, input logic stall);
        bus.req_valid = reqValid;
        rdy_in        = rdy;
        clear         = clr;
        cdb_stall     = stall;
        tick();
    endtask

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        clear         = 1'b0;
        cdb_stall     = 1'b0;
        bus.req_valid = '0;
        bus.rob_head  = '0;
        for (int i = 0; i < 8; i++) bus.req_rob[i*`ROB_BIT +: `ROB_BIT] = 5'(i + 10);

        #2;
        checkGrant("reset", 8'h00, 3'd0, 5'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkGrant("postResetIdle", 8'h00, 3'd0, 5'd0);

`ifdef ALU_SCHED_OLDEST_EN
        bus.rob_head = 5'd6;
        bus.req_rob[2*`ROB_BIT +: `ROB_BIT] = 5'd7;
        bus.req_rob[5*`ROB_BIT +: `ROB_BIT] = 5'd1;
        bus.req_rob[6*`ROB_BIT +: `ROB_BIT] = 5'd7;
        applyStimulus(8'h64, 1'b1, 1'b0, 1'b0);
        checkGrant("oldest", 8'h04, 3'd2, 5'd7);
        applyStimulus(8'h64, 1'b1, 1'b0, 1'b0);
        checkGrant("oldestMask", 8'h40, 3'd6, 5'd7);
        applyStimulus(8'h64, 1'b1, 1'b0, 1'b0);
        checkGrant("oldestAgain", 8'h04, 3'd2, 5'd7);
`else
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
            checkGrant($sformatf("rr%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 5'(10 + k % 8));
        end

        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);
        checkGrant("stall", 8'h00, 3'd0, 5'd10);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        checkGrant("afterStall", 8'h02, 3'd1, 5'd11);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        checkGrant("preHold", 8'h04, 3'd2, 5'd12);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1);
            checkGrant($sformatf("hold%0d", k), 8'h04, 3'd2, 5'd12);
        end
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        checkGrant("resume", 8'h08, 3'd3, 5'd13);

        applyStimulus(8'h40, 1'b1, 1'b0, 1'b0);
        checkGrant("toPtr7", 8'h40, 3'd6, 5'd16);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
        checkGrant("wrapA", 8'h80, 3'd7, 5'd17);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
        checkGrant("wrapB", 8'h01, 3'd0, 5'd10);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
        checkGrant("wrapC", 8'h80, 3'd7, 5'd17);

        applyStimulus(8'h10, 1'b1, 1'b1, 1'b0);
        checkGrant("flush", 8'h00, 3'd7, 5'd17);
        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0);
        checkGrant("afterFlush", 8'h10, 3'd4, 5'd14);
        applyStimulus(8'h21, 1'b1, 1'b1, 1'b0);
        checkGrant("flush2", 8'h00, 3'd4, 5'd14);
        applyStimulus(8'h21, 1'b1, 1'b0, 1'b0);
        checkGrant("ptrZeroed", 8'h01, 3'd0, 5'd10);

        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkGrant("idle", 8'h00, 3'd0, 5'd10);
`endif

        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        checkOutput("preAsync.valid", 32'(bus.alu_valid), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        checkGrant("asyncReset", 8'h00, 3'd0, 5'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkGrant("releaseIdle", 8'h00, 3'd0, 5'd0);
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
        checkGrant("releaseReq", 8'h08, 3'd3, 5'd13);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
